aq_djpeg_bitstream: RTL and testbench

//  Entropy-coded-segment bit feeder sitting directly upstream of aq_djpeg_huffman.
//  - Accepts scan bytes from the header parser / input FIFO and strips 0xFF00 stuffing.
//  - Detects RSTn/EOI/other markers.
//  - Presents a 32-bit MSB-aligned window on DataOut, consuming bits per DecodeUseBit/DecodeUseWidth.
//  - Performs byte alignment and RST-marker skip on DecodeAlignByte.

---
 rtl/aq_djpeg_bitstream_pkg.sv | 21 ++
 rtl/aq_djpeg_bitstream_unstuff.sv | 66 ++++++
 rtl/aq_djpeg_bitstream.sv | 118 +++++++++++
 tb/tb_aq_djpeg_bitstream.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_djpeg_bitstream_pkg.sv
// Shared definitions for the JPEG entropy-segment bit feeder: byte-FSM states and marker codes.
package aq_djpeg_bitstream_pkg;

    typedef enum logic [1:0] {
        S_DATA = 2'd0,
        S_FF   = 2'd1,
        S_RST  = 2'd2,
        S_HALT = 2'd3
    } byteState_t;

    localparam logic [7:0] M_STUFF = 8'h00;
    localparam logic [7:0] M_FILL  = 8'hFF;
    localparam logic [7:0] M_RST0  = 8'hD0;
    localparam logic [7:0] M_RST7  = 8'hD7;
    localparam logic [7:0] M_EOI   = 8'hD9;

    function automatic logic isRstMarker(input logic [7:0] code);
        return (code >= M_RST0) && (code <= M_RST7);
    endfunction

endpackage

// File: rtl/aq_djpeg_bitstream_unstuff.sv
// Byte-level FSM: removes FF00 stuffing, swallows fill bytes and classifies markers.
module aq_djpeg_bitstream_unstuff
    import aq_djpeg_bitstream_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       processInit,
    input  logic       accept,
    input  logic [7:0] inData,
    input  logic       alignPend,
    input  logic       alignExit,
    output byteState_t state,
    output logic       push,
    output logic [7:0] pushData,
    output logic       rstSkip,
    output logic       markerHit,
    output logic [7:0] markerCode
);

    byteState_t stateNext;

    // NOTE: state register and next-state logic are split; the register is the only
    // place with non-blocking assignments, the combinational block defaults every output first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              state <= S_DATA;
        else if (processInit) state <= S_DATA;
        else                  state <= stateNext;
    end

    always_comb begin
        stateNext  = state;
        push       = 1'b0;
        pushData   = inData;
        rstSkip    = 1'b0;
        markerHit  = 1'b0;
        markerCode = inData;
        if (alignExit) begin
            stateNext = S_DATA;
        end else if (accept) begin
            unique case (state)
                S_DATA: begin
                    if (inData == M_FILL) stateNext = S_FF;
                    else                  push      = 1'b1;
                end
                S_FF: begin
                    if (inData == M_STUFF) begin
                        push      = 1'b1;
                        pushData  = M_FILL;
                        stateNext = S_DATA;
                    end else if (inData == M_FILL) begin
                        stateNext = S_FF;
                    end else if (isRstMarker(inData)) begin
                        // An earlier align already consumed this restart interval boundary.
                        rstSkip   = alignPend;
                        stateNext = alignPend ? S_DATA : S_RST;
                    end else begin
                        markerHit = 1'b1;
                        stateNext = S_HALT;
                    end
                end
                default: stateNext = state;
            endcase
        end
    end

endmodule

// File: rtl/aq_djpeg_bitstream.sv
// Entropy-coded-segment bit feeder: MSB-aligned shift buffer presenting a 1-padded window to the huffman decoder.
module aq_djpeg_bitstream
    import aq_djpeg_bitstream_pkg::*;
#(
    parameter int BUF_W = 64,
    parameter int WIN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ProcessInit,
    input  logic             InValid,
    input  logic [7:0]       InData,
    output logic             InReady,
    output logic [WIN_W-1:0] DataOut,
    output logic             DataOutEnable,
    input  logic             DecodeUseBit,
    input  logic [6:0]       DecodeUseWidth,
    input  logic             DecodeAlignByte,
    output logic             MarkerDetected,
    output logic [7:0]       MarkerCode,
    output logic             StreamEnd,
    output logic             Underrun
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    byteState_t       state;
    logic [BUF_W-1:0] shiftBuf, bufNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             alignPend, accept, alignExit, underrunSet;
    logic             push, rstSkip, markerHit;
    logic [7:0]       pushData, markerCode;
    logic [2:0]       alignRem;

    assign InReady   = ((state == S_DATA) || (state == S_FF)) && (cnt <= CNT_W'(BUF_W - 8));
    assign accept    = InValid && InReady;
    assign alignExit = DecodeAlignByte && (state == S_RST);
    assign alignRem  = cnt[2:0];

    aq_djpeg_bitstream_unstuff uUnstuff (
        .clk        (clk),
        .rst        (rst),
        .processInit(ProcessInit),
        .accept     (accept),
        .inData     (InData),
        .alignPend  (alignPend),
        .alignExit  (alignExit),
        .state      (state),
        .push       (push),
        .pushData   (pushData),
        .rstSkip    (rstSkip),
        .markerHit  (markerHit),
        .markerCode (markerCode)
    );

    // Bits below cnt are always zero, so an incoming byte can simply be OR-ed in.
    always_comb begin
        bufNext     = shiftBuf;
        cntNext     = cnt;
        underrunSet = 1'b0;
        if (DecodeUseBit) begin
            bufNext = shiftBuf << DecodeUseWidth;
            if (int'(DecodeUseWidth) > int'(cnt)) begin
                cntNext     = '0;
                underrunSet = 1'b1;
            end else begin
                cntNext = cnt - CNT_W'(DecodeUseWidth);
            end
        end else if (DecodeAlignByte) begin
            bufNext = shiftBuf << alignRem;
            cntNext = cnt - CNT_W'(alignRem);
        end
        if (push) begin
            bufNext = bufNext | (BUF_W'(pushData) << (CNT_W'(BUF_W - 8) - cntNext));
            cntNext = cntNext + CNT_W'(8);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shiftBuf       <= '0;
            cnt            <= '0;
            alignPend      <= 1'b0;
            MarkerDetected <= 1'b0;
            MarkerCode     <= '0;
            StreamEnd      <= 1'b0;
            Underrun       <= 1'b0;
        end else if (ProcessInit) begin
            shiftBuf       <= '0;
            cnt            <= '0;
            alignPend      <= 1'b0;
            MarkerDetected <= 1'b0;
            MarkerCode     <= '0;
            StreamEnd      <= 1'b0;
            Underrun       <= 1'b0;
        end else begin
            shiftBuf       <= bufNext;
            cnt            <= cntNext;
            MarkerDetected <= markerHit;
            if (markerHit) begin
                MarkerCode <= markerCode;
                if (markerCode == M_EOI) StreamEnd <= 1'b1;
            end
            if (underrunSet) Underrun <= 1'b1;
            if (DecodeAlignByte && (state != S_RST)) alignPend <= 1'b1;
            else if (rstSkip)                        alignPend <= 1'b0;
        end
    end

    // Positions at or beyond cnt read as 1 so the decoder sees JPEG fill bits.
    always_comb begin
        DataOut = shiftBuf[BUF_W-1 -: WIN_W];
        if (int'(cnt) < WIN_W) DataOut = DataOut | ({WIN_W{1'b1}} >> cnt);
    end

    assign DataOutEnable = (int'(cnt) >= WIN_W) || (state == S_RST) || (state == S_HALT);

endmodule

// File: tb/tb_aq_djpeg_bitstream.sv
// Scoreboard bench for aq_djpeg_bitstream: directed byte/consume vectors, expectations queued, checked by monitors.
module tb_aq_djpeg_bitstream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ProcessInit = 1'b0;
    logic        InValid = 1'b0;
    logic [7:0]  InData = '0;
    logic        InReady;
    logic [31:0] DataOut;
    logic        DataOutEnable;
    logic        DecodeUseBit = 1'b0;
    logic [6:0]  DecodeUseWidth = '0;
    logic        DecodeAlignByte = 1'b0;
    logic        MarkerDetected;
    logic [7:0]  MarkerCode;
    logic        StreamEnd;
    logic        Underrun;

    typedef struct packed {
        logic [31:0] dout;
        logic        en;
        logic        rdy;
        logic [7:0]  code;
        logic        se;
        logic        ur;
    } snap_t;

    snap_t      expQ[$];
    string      nameQ[$];
    logic [7:0] markerQ[$];
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    aq_djpeg_bitstream dut (
        .clk            (clk),
        .rst            (rst),
        .ProcessInit    (ProcessInit),
        .InValid        (InValid),
        .InData         (InData),
        .InReady        (InReady),
        .DataOut        (DataOut),
        .DataOutEnable  (DataOutEnable),
        .DecodeUseBit   (DecodeUseBit),
        .DecodeUseWidth (DecodeUseWidth),
        .DecodeAlignByte(DecodeAlignByte),
        .MarkerDetected (MarkerDetected),
        .MarkerCode     (MarkerCode),
        .StreamEnd      (StreamEnd),
        .Underrun       (Underrun)
    );

    always @(posedge clk)
        assert (!(DecodeAlignByte && DecodeUseBit)) else $error("align and consume issued together");

    // Snapshot monitor: compares every queued expectation at the mid-cycle edge.
    always @(negedge clk) begin
        snap_t e, a;
        string nm;
        while (expQ.size() > 0) begin
            e  = expQ.pop_front();
            nm = nameQ.pop_front();
            a  = '{dout: DataOut, en: DataOutEnable, rdy: InReady, code: MarkerCode,
                   se: StreamEnd, ur: Underrun};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got dout=%h en=%b rdy=%b code=%h se=%b ur=%b, want dout=%h en=%b rdy=%b code=%h se=%b ur=%b",
                         nm, a.dout, a.en, a.rdy, a.code, a.se, a.ur,
                         e.dout, e.en, e.rdy, e.code, e.se, e.ur);
            end
        end
    end

    // Marker monitor: every pulse must match a queued expected code.
    always @(negedge clk) begin
        logic [7:0] c;
        if (!rst && MarkerDetected) begin
            total++;
            if (markerQ.size() == 0) begin
                bad++;
                $display("FAIL marker_pulse: got unexpected pulse code=%h, want no pulse", MarkerCode);
            end else begin
                c = markerQ.pop_front();
                if (MarkerCode !== c) begin
                    bad++;
                    $display("FAIL marker_pulse: got code=%h, want %h", MarkerCode, c);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input string n, input logic [31:0] d, input logic en, input logic rdy,
                        input logic [7:0] code, input logic se, input logic ur);
        expQ.push_back('{dout: d, en: en, rdy: rdy, code: code, se: se, ur: ur});
        nameQ.push_back(n);
    endtask

    task automatic pushByte(input logic [7:0] b);
        InValid = 1'b1;
        InData  = b;
        tick();
        InValid = 1'b0;
    endtask

    task automatic consume(input int w);
        DecodeUseBit   = 1'b1;
        DecodeUseWidth = 7'(w);
        tick();
        DecodeUseBit   = 1'b0;
    endtask

    task automatic pushConsume(input logic [7:0] b, input int w);
        InValid        = 1'b1;
        InData         = b;
        DecodeUseBit   = 1'b1;
        DecodeUseWidth = 7'(w);
        tick();
        InValid        = 1'b0;
        DecodeUseBit   = 1'b0;
    endtask

    task automatic alignByte();
        DecodeAlignByte = 1'b1;
        tick();
        DecodeAlignByte = 1'b0;
    endtask

    // ProcessInit with a competing byte must still win.
    task automatic procInit();
        ProcessInit = 1'b1;
        InValid     = 1'b1;
        InData      = 8'h11;
        tick();
        ProcessInit = 1'b0;
        InValid     = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        snap("reset", 32'hFFFF_FFFF, 0, 1, 8'h00, 0, 0);

        // Plain data, first enable, consume, simultaneous push+consume, ready boundary
        pushByte(8'h12); pushByte(8'h34); pushByte(8'h56);
        snap("t1_three_bytes", 32'h1234_56FF, 0, 1, 8'h00, 0, 0);
        pushByte(8'h78);
        snap("t1_four_bytes", 32'h1234_5678, 1, 1, 8'h00, 0, 0);
        pushByte(8'h9A);
        snap("t1_five_bytes", 32'h1234_5678, 1, 1, 8'h00, 0, 0);
        consume(4);
        snap("t1_use4", 32'h2345_6789, 1, 1, 8'h00, 0, 0);
        pushConsume(8'hBC, 8);
        snap("t1_push_and_use8", 32'h4567_89AB, 1, 1, 8'h00, 0, 0);
        pushByte(8'h01); pushByte(8'h02);
        snap("t1_cnt52_ready", 32'h4567_89AB, 1, 1, 8'h00, 0, 0);
        pushByte(8'h03);
        snap("t1_cnt60_full", 32'h4567_89AB, 1, 0, 8'h00, 0, 0);
        pushByte(8'h04);
        consume(32);
        snap("t1_drain32", 32'hC010_203F, 0, 1, 8'h00, 0, 0);
        procInit();
        snap("t1_init", 32'hFFFF_FFFF, 0, 1, 8'h00, 0, 0);

        // Byte stuffing
        pushByte(8'hAB); pushByte(8'hFF);
        snap("t2_after_ff", 32'hABFF_FFFF, 0, 1, 8'h00, 0, 0);
        pushByte(8'h00);
        snap("t2_after_stuff", 32'hABFF_FFFF, 0, 1, 8'h00, 0, 0);
        pushByte(8'hCD); pushByte(8'hEF); pushByte(8'h01);
        snap("t2_unstuffed", 32'hABFF_CDEF, 1, 1, 8'h00, 0, 0);
        procInit();

        // EOI halts the stream
        pushByte(8'h55); pushByte(8'hFF);
        markerQ.push_back(8'hD9);
        pushByte(8'hD9);
        snap("t3_eoi", 32'h55FF_FFFF, 1, 0, 8'hD9, 1, 0);
        InValid = 1'b1; InData = 8'h77;
        tick(); tick();
        InValid = 1'b0;
        snap("t3_halt_ignores", 32'h55FF_FFFF, 1, 0, 8'hD9, 1, 0);
        procInit();

        // RST marker stalls until align
        pushByte(8'h12); pushByte(8'h34); pushByte(8'h56); pushByte(8'h78);
        consume(19);
        snap("t4_cnt13", 32'hB3C7_FFFF, 0, 1, 8'h00, 0, 0);
        pushByte(8'hFF); pushByte(8'hD0);
        snap("t4_rst_stall", 32'hB3C7_FFFF, 1, 0, 8'h00, 0, 0);
        pushByte(8'h66);
        snap("t4_rst_ignores", 32'hB3C7_FFFF, 1, 0, 8'h00, 0, 0);
        alignByte();
        snap("t4_aligned", 32'h78FF_FFFF, 0, 1, 8'h00, 0, 0);
        pushByte(8'h66);
        snap("t4_resume", 32'h7866_FFFF, 0, 1, 8'h00, 0, 0);
        procInit();

        // Align ahead of the marker: RSTn skipped once, then stalls again
        pushByte(8'hA5);
        alignByte();
        snap("t5_align_pend", 32'hA5FF_FFFF, 0, 1, 8'h00, 0, 0);
        pushByte(8'hFF); pushByte(8'hD3);
        snap("t5_rst_skipped", 32'hA5FF_FFFF, 0, 1, 8'h00, 0, 0);
        pushByte(8'h11); pushByte(8'h22); pushByte(8'h33);
        snap("t5_data_after", 32'hA511_2233, 1, 1, 8'h00, 0, 0);
        pushByte(8'hFF); pushByte(8'hD4);
        snap("t5_pend_cleared", 32'hA511_2233, 1, 0, 8'h00, 0, 0);
        procInit();

        // Underrun in HALT, then init clears everything
        pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC); pushByte(8'hFF);
        markerQ.push_back(8'hD9);
        pushByte(8'hD9);
        snap("t6_halt", 32'hAABB_CCFF, 1, 0, 8'hD9, 1, 0);
        consume(4);
        snap("t6_cnt20", 32'hABBC_CFFF, 1, 0, 8'hD9, 1, 0);
        consume(32);
        snap("t6_underrun", 32'hFFFF_FFFF, 1, 0, 8'hD9, 1, 1);
        procInit();
        snap("t6_init", 32'hFFFF_FFFF, 0, 1, 8'h00, 0, 0);

        // Asynchronous reset mid-operation
        pushByte(8'h12);
        #2 rst = 1'b1;
        snap("async_reset", 32'hFFFF_FFFF, 0, 1, 8'h00, 0, 0);
        tick();
        rst = 1'b0;

        repeat (3) tick();
        total++;
        if (markerQ.size() != 0) begin
            bad++;
            $display("FAIL marker_pulse_missing: got %0d pending, want 0", markerQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, want finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
